// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_pkg
//  Desc    : Shared constants, event type and deframer states for ps2_key_rx.
//  Rev     : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
    localparam int         PAUSE_SKIP    = 7;
    localparam int         EVENT_W       = 10;

    typedef enum logic [1:0] {
        DF_IDLE   = 2'd0,
        DF_DATA   = 2'd1,
        DF_PARITY = 2'd2,
        DF_STOP   = 2'd3
    } ps2_df_state_e;

    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ps2_event_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_rx_if.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_key_rx_if
//  Desc    : Valid/ready key-event channel from ps2_key_rx to its consumer.
//  Rev     : 1.0  initial release
// ============================================================================
interface ps2_key_rx_if;
    import ps2_pkg::*;

    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_pressed;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_pressed,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_pressed,
        output ev_ready
    );

endinterface
`default_nettype wire

// File: rtl/ps2_ev_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_ev_fifo
//  Desc    : Synchronous event FIFO, valid/ready on the read side, drop flag
//            when written while full without a same-cycle pop.
//  Rev     : 1.0  initial release
// ============================================================================
module ps2_ev_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = EVENT_W,
    parameter int DEPTH = 8
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              i_push,
    input  wire [WIDTH-1:0]  i_data,
    output logic             o_drop,
    output logic             o_valid,
    input  wire              i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = (c_AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign w_wr    = i_push && (!w_full || w_pop);

    assign o_drop  = i_push && w_full && !w_pop;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[c_AW-1:0]] <= i_data;
                r_wptr                  <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_rx.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_key_rx
//  Desc    : PS/2 keyboard receiver: input filter, frame deframer with
//            watchdog, prefix folding, event FIFO and legacy toggle strobe.
//  Rev     : 1.0  initial release
// ============================================================================
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 3250000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 8
) (
    input  wire          clk,
    input  wire          reset,
    input  wire          ps2_clk,
    input  wire          ps2_data,
    ps2_key_rx_if.master ev_if,
    output logic [10:0]  ps2_key,
    output logic         frame_err,
    output logic         overflow,
    input  wire          ovf_clr
);

    localparam longint c_WD_CYCLES_L = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / 64'd1000000;
    localparam int     c_WD_CYCLES   = int'(c_WD_CYCLES_L);
    localparam int     c_WDW         = $clog2(c_WD_CYCLES + 1);
    localparam int     c_FW          = $clog2(FILTER_LEN + 1);
    localparam int     c_SKW         = $clog2(PAUSE_SKIP + 1);

    localparam logic [1:0] c_ST_IDLE   = DF_IDLE;
    localparam logic [1:0] c_ST_DATA   = DF_DATA;
    localparam logic [1:0] c_ST_PARITY = DF_PARITY;
    localparam logic [1:0] c_ST_STOP   = DF_STOP;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_filt;
    logic [c_FW-1:0]        r_filt_cnt;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_filt_hit;
    logic                   w_fall;

    logic [1:0]             r_state;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [c_WDW-1:0]       r_wd;
    logic                   w_timeout;
    logic                   r_rx_done;
    logic [7:0]             r_rx_byte;
    logic                   r_frame_err;

    logic                   r_ext;
    logic                   r_brk;
    logic [c_SKW-1:0]       r_skip;
    logic                   w_is_pfx;
    logic                   w_push;
    ps2_event_t             w_ev;

    ps2_event_t             w_head;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_drop;
    logic [10:0]            r_ps2_key;
    logic                   r_overflow;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // The filtered level only moves after FILTER_LEN consecutive differing samples.
    assign w_filt_hit = (w_clk_s != r_clk_filt) && (r_filt_cnt == c_FW'(FILTER_LEN - 1));
    assign w_fall     = w_filt_hit && !w_clk_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_clk_filt) begin
            r_filt_cnt <= '0;
        end else if (w_filt_hit) begin
            r_clk_filt <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + c_FW'(1);
        end
    end

    assign w_timeout = (r_state != c_ST_IDLE) && !w_fall &&
                       (r_wd == c_WDW'(c_WD_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd <= '0;
        end else if ((r_state == c_ST_IDLE) || w_fall || w_timeout) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + c_WDW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_rx_done   <= 1'b0;
            r_rx_byte   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_timeout) begin
                r_state     <= c_ST_IDLE;
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!w_dat_s) begin
                            r_state  <= c_ST_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    c_ST_DATA: begin
                        r_shift  <= {w_dat_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= c_ST_PARITY;
                        end
                    end
                    c_ST_PARITY: begin
                        r_par   <= w_dat_s;
                        r_state <= c_ST_STOP;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        if (w_dat_s && odd_parity_ok(r_shift, r_par)) begin
                            r_rx_done <= 1'b1;
                            r_rx_byte <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Prefix bytes only update flags; a pending Pause skip swallows any byte.
    assign w_is_pfx = (r_rx_byte == PS2_PFX_EXT) || (r_rx_byte == PS2_PFX_BRK) ||
                      (r_rx_byte == PS2_PFX_PAUSE);
    assign w_push   = r_rx_done && (r_skip == '0) && !w_is_pfx;

    always_comb begin
        w_ev         = '0;
        w_ev.pressed = !r_brk;
        w_ev.ext     = r_ext;
        w_ev.code    = r_rx_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_rx_done) begin
            if (r_skip != '0) begin
                r_skip <= r_skip - c_SKW'(1);
            end else if (r_rx_byte == PS2_PFX_PAUSE) begin
                r_skip <= c_SKW'(PAUSE_SKIP);
            end else if (r_rx_byte == PS2_PFX_EXT) begin
                r_ext <= 1'b1;
            end else if (r_rx_byte == PS2_PFX_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    ps2_ev_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_ev),
        .o_drop  (w_drop),
        .o_valid (w_valid),
        .i_ready (ev_if.ev_ready),
        .o_data  (w_head)
    );

    assign w_pop            = w_valid && ev_if.ev_ready;
    assign ev_if.ev_valid   = w_valid;
    assign ev_if.ev_code    = w_head.code;
    assign ev_if.ev_ext     = w_head.ext;
    assign ev_if.ev_pressed = w_head.pressed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ps2_key  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ps2_key <= {~r_ps2_key[10], w_head.pressed, w_head.ext, w_head.code};
            end
            if (ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ps2_key   = r_ps2_key;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
